bitplane_serializer: RTL and testbench



---
 rtl/bitplane_serializer.sv | 160 ++++++++++++++++
 tb/tb_bitplane_serializer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitplane_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : bitplane_serializer
//  Description : Reads DEPTH words of WIDTH bits from an asynchronous-read
//                register bank and streams them out one bit-plane per frame.
//                Each frame is an HW-bit frame-number header (MSB first)
//                followed by one bit of every word, highest address first.
//                A start/busy/done handshake frames the transfer, plane
//                order is selectable, and GAP idle cycles separate frames.
//  Ports       : clk    - clock, rising edge
//                rst    - synchronous active-high reset
//                start  - transfer request, sampled only when idle
//                mode   - 0: MSB plane first, 1: LSB plane first (latched)
//                busy   - transfer in progress
//                done   - one-cycle pulse at end of transfer
//                RB_RW  - bank read/write control, constant read (1)
//                RB_A   - bank address (registered)
//                RB_D   - bank write data, constant 0
//                RB_Q   - bank read data, follows RB_A combinationally
//                sen    - serial enable, active low
//                sd     - serial data
//  Revision    : 1.0 - initial release
// ============================================================================
module bitplane_serializer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 18,
    parameter int AW    = 5,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    output logic             busy,
    output logic             done,
    output logic             RB_RW,
    output logic [AW-1:0]    RB_A,
    output logic [WIDTH-1:0] RB_D,
    input  logic [WIDTH-1:0] RB_Q,
    output logic             sen,
    output logic             sd
);

    localparam int HW    = $clog2(WIDTH);
    // One shared counter walks both the header bits and the gap cycles.
    localparam int CNT_W = $clog2(HW + GAP + 1) + 1;

    localparam logic [AW-1:0] c_addr_top = AW'(DEPTH - 1);
    localparam logic [HW-1:0] c_k_last   = HW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_DATA = 3'd2,
        S_GAP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t           r_state;
    logic [HW-1:0]    r_k;      // current frame number
    logic [HW-1:0]    r_hdr;    // header shift register, MSB goes out first
    logic             r_mode;   // plane order latched at start
    logic [CNT_W-1:0] r_cnt;
    logic [HW-1:0]    w_plane;

    assign RB_RW = 1'b1;
    assign RB_D  = '0;

    // Frame k carries plane k (LSB first) or plane WIDTH-1-k (MSB first).
    always_comb begin
        w_plane = r_mode ? r_k : (c_k_last - r_k);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_hdr   <= '0;
            r_mode  <= 1'b0;
            r_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sen     <= 1'b1;
            sd      <= 1'b0;
            RB_A    <= c_addr_top;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    sen <= 1'b1;
                    sd  <= 1'b0;
                    if (start) begin
                        r_mode  <= mode;
                        r_k     <= '0;
                        r_hdr   <= '0;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_HDR;
                    end
                end

                S_HDR: begin
                    sen   <= 1'b0;
                    sd    <= r_hdr[HW-1];
                    r_hdr <= r_hdr << 1;
                    if (r_cnt == CNT_W'(HW - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DATA: begin
                    sen <= 1'b0;
                    sd  <= RB_Q[w_plane];
                    // Address 0 is the last word of the plane; the counter
                    // wraps so the next frame starts from the top again.
                    if (RB_A == '0) begin
                        RB_A <= c_addr_top;
                        if (r_k == c_k_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_k     <= r_k + 1'b1;
                            r_hdr   <= r_k + 1'b1;
                            r_state <= (GAP == 0) ? S_HDR : S_GAP;
                        end
                    end else begin
                        RB_A <= RB_A - 1'b1;
                    end
                end

                S_GAP: begin
                    sen <= 1'b1;
                    sd  <= 1'b0;
                    if (r_cnt == CNT_W'(GAP - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_HDR;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    sen     <= 1'b1;
                    sd      <= 1'b0;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bitplane_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bitplane_serializer
//  Description : Self-checking bench for bitplane_serializer. Two instances
//                share stimulus: dut 0 with default GAP=1, dut 1 with GAP=0.
//                Per-cycle output traces are compared against a frame-level
//                reference model and a table of hand-derived points.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bitplane_serializer;

    localparam int W  = 8;
    localparam int D  = 18;
    localparam int HB = 3;
    localparam int NT = 400;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       mode = 1'b0;

    logic       busy0, done0, rbrw0, sen0, sd0;
    logic [4:0] rba0;
    logic [7:0] rbd0, rbq0;
    logic       busy1, done1, rbrw1, sen1, sd1;
    logic [4:0] rba1;
    logic [7:0] rbd1, rbq1;

    logic [7:0] bank [0:31];

    assign rbq0 = bank[rba0];
    assign rbq1 = bank[rba1];

    always #5 clk = ~clk;

    bitplane_serializer #(.WIDTH(8), .DEPTH(18), .AW(5), .GAP(1)) dut0 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy0), .done(done0), .RB_RW(rbrw0), .RB_A(rba0),
        .RB_D(rbd0), .RB_Q(rbq0), .sen(sen0), .sd(sd0)
    );

    bitplane_serializer #(.WIDTH(8), .DEPTH(18), .AW(5), .GAP(0)) dut1 (
        .clk(clk), .rst(rst), .start(start), .mode(mode),
        .busy(busy1), .done(done1), .RB_RW(rbrw1), .RB_A(rba1),
        .RB_D(rbd1), .RB_Q(rbq1), .sen(sen1), .sd(sd1)
    );

    // Traces: index n holds the outputs after edge T0+n.
    logic       tr_sen  [0:1][0:NT-1];
    logic       tr_sd   [0:1][0:NT-1];
    logic       tr_busy [0:1][0:NT-1];
    logic       tr_done [0:1][0:NT-1];
    logic [4:0] tr_a    [0:1][0:NT-1];

    // Model: e_*[n] are the expected outputs after edge T0+n.
    logic       e_sen [0:NT-1];
    logic       e_sd  [0:NT-1];
    int         e_a   [0:NT-1];
    int         e_done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int         off;
        logic [8:0] exp;   // {sen, sd, busy, done, RB_A}
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic logic [8:0] mk(input logic s, input logic b, input logic bz,
                                      input logic dn, input int a);
        return {s, b, bz, dn, 5'(a)};
    endfunction

    // Frame-level description of the expected stream for the current bank.
    task automatic build_model(input bit m, input int gap);
        int n;
        int p;
        n = 0;
        e_a[0] = D - 1;
        for (int k = 0; k < W; k++) begin
            p = m ? k : (W - 1 - k);
            for (int i = 0; i < HB; i++) begin
                n++;
                e_sen[n] = 1'b0;
                e_sd[n]  = 1'((k >> (HB - 1 - i)) & 1);
                e_a[n]   = D - 1;
            end
            for (int j = 0; j < D; j++) begin
                n++;
                e_sen[n]   = 1'b0;
                e_sd[n]    = bank[D - 1 - j][p];
                e_a[n - 1] = D - 1 - j;   // address presented before this edge
                e_a[n]     = D - 1;
            end
            if (k < W - 1) begin
                for (int g = 0; g < gap; g++) begin
                    n++;
                    e_sen[n] = 1'b1;
                    e_sd[n]  = 1'b0;
                    e_a[n]   = D - 1;
                end
            end
        end
        n++;
        e_sen[n] = 1'b1;
        e_sd[n]  = 1'b0;
        e_a[n]   = D - 1;
        e_done   = n;
    endtask

    task automatic cmp_transfer(input string name, input int d, input int base,
                                input bit m, input int gap);
        int ns, na, nb, fs, fa, fb;
        build_model(m, gap);
        ns = 0; na = 0; nb = 0; fs = -1; fa = -1; fb = -1;
        for (int n = 0; n <= e_done; n++) begin
            if (n > 0 && (tr_sen[d][base+n] !== e_sen[n] || tr_sd[d][base+n] !== e_sd[n])) begin
                ns++;
                if (fs < 0) fs = n;
            end
            if (tr_a[d][base+n] !== 5'(e_a[n])) begin
                na++;
                if (fa < 0) fa = n;
            end
            if (tr_busy[d][base+n] !== (n < e_done) || tr_done[d][base+n] !== (n == e_done)) begin
                nb++;
                if (fb < 0) fb = n;
            end
        end
        chk($sformatf("%s serial stream errors (first at T0+%0d)", name, fs), ns, 0);
        chk($sformatf("%s RB_A errors (first at T0+%0d)", name, fa), na, 0);
        chk($sformatf("%s busy/done errors (first at T0+%0d)", name, fb), nb, 0);
    endtask

    function automatic int count_done(input int d, input int lo, input int hi);
        int c = 0;
        for (int n = lo; n <= hi; n++) if (tr_done[d][n] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_done(input int d, input int lo, input int hi);
        for (int n = lo; n <= hi; n++) if (tr_done[d][n] === 1'b1) return n;
        return -1;
    endfunction

    // Caller raises start before calling; the first edge seen is T0.
    task automatic capture(input int ncyc, input int hold, input int p1, input int p2,
                           input int rstat, input bit rnd_mode);
        for (int n = 0; n < ncyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            tr_sen[0][n] = sen0; tr_sd[0][n] = sd0; tr_busy[0][n] = busy0;
            tr_done[0][n] = done0; tr_a[0][n] = rba0;
            tr_sen[1][n] = sen1; tr_sd[1][n] = sd1; tr_busy[1][n] = busy1;
            tr_done[1][n] = done1; tr_a[1][n] = rba1;
            start = ((n + 1) < hold) || ((n + 1) == p1) || ((n + 1) == p2);
            rst   = ((n + 1) == rstat);
            if (rnd_mode) mode = 1'($urandom);
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset state dut0 {sen,sd,busy,done,RB_A,RB_RW,RB_D}",
            int'({sen0, sd0, busy0, done0, rba0, rbrw0, rbd0}),
            int'({1'b1, 1'b0, 1'b0, 1'b0, 5'd17, 1'b1, 8'h00}));
        chk("reset state dut1 {sen,sd,busy,done,RB_A}",
            int'({sen1, sd1, busy1, done1, rba1}),
            int'({1'b1, 1'b0, 1'b0, 1'b0, 5'd17}));
        rst = 1'b0;
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < 32; i++) bank[i] = v;
    endtask

    int t;
    bit rm;

    initial begin
        fill(8'h00);

        // Hand-derived points for all words = 0x80, MSB plane first.
        tbl[0]  = '{0,   mk(1, 0, 1, 0, 17)};
        tbl[1]  = '{1,   mk(0, 0, 1, 0, 17)};
        tbl[2]  = '{3,   mk(0, 0, 1, 0, 17)};
        tbl[3]  = '{4,   mk(0, 1, 1, 0, 16)};
        tbl[4]  = '{21,  mk(0, 1, 1, 0, 17)};
        tbl[5]  = '{22,  mk(1, 0, 1, 0, 17)};
        tbl[6]  = '{25,  mk(0, 1, 1, 0, 17)};
        tbl[7]  = '{26,  mk(0, 0, 1, 0, 16)};
        tbl[8]  = '{157, mk(0, 1, 1, 0, 17)};
        tbl[9]  = '{175, mk(0, 0, 1, 0, 17)};
        tbl[10] = '{176, mk(1, 0, 0, 1, 17)};
        tbl[11] = '{177, mk(1, 0, 0, 0, 17)};

        do_reset();

        // Test 1 (dut0) and test 3 (dut1, GAP=0) from the same start pulse.
        fill(8'h80);
        mode = 1'b0;
        @(negedge clk);
        start = 1'b1;
        capture(180, 1, -1, -1, -1, 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("table point T0+%0d {sen,sd,busy,done,RB_A}", tbl[i].off),
                int'({tr_sen[0][tbl[i].off], tr_sd[0][tbl[i].off], tr_busy[0][tbl[i].off],
                      tr_done[0][tbl[i].off], tr_a[0][tbl[i].off]}),
                int'(tbl[i].exp));
        end
        cmp_transfer("t1 msb-first 0x80", 0, 0, 1'b0, 1);
        cmp_transfer("t3 gap0", 1, 0, 1'b0, 0);
        t = 0;
        for (int n = 1; n <= 168; n++) if (tr_sen[1][n] === 1'b0) t++;
        chk("t3 gap0 sen-low cycles T1..T168", t, 168);
        chk("t3 gap0 done position", first_done(1, 0, 179), 169);

        // Test 2: LSB plane first, only word 17 = 0x01.
        fill(8'h00);
        bank[17] = 8'h01;
        mode = 1'b1;
        @(negedge clk);
        start = 1'b1;
        capture(180, 1, -1, -1, -1, 1'b0);
        chk("t2 first data bit", int'(tr_sd[0][4]), 1);
        cmp_transfer("t2 lsb-first word17", 0, 0, 1'b1, 1);

        // Test 4: start pulses while busy are ignored.
        fill(8'h80);
        mode = 1'b0;
        @(negedge clk);
        start = 1'b1;
        capture(180, 1, 10, 100, -1, 1'b0);
        cmp_transfer("t4 start-while-busy", 0, 0, 1'b0, 1);
        chk("t4 done pulse count", count_done(0, 0, 179), 1);

        // Test 5: reset at T50 aborts, then a fresh transfer completes.
        fill(8'h80);
        @(negedge clk);
        start = 1'b1;
        capture(120, 1, -1, -1, 50, 1'b0);
        chk("t5 outputs at reset edge {sen,sd,busy}",
            int'({tr_sen[0][50], tr_sd[0][50], tr_busy[0][50]}), int'(3'b100));
        chk("t5 done pulses after abort", count_done(0, 0, 119), 0);
        for (int i = 0; i < D; i++) bank[i] = 8'($urandom);
        mode = 1'b1;
        @(negedge clk);
        start = 1'b1;
        capture(180, 1, -1, -1, -1, 1'b0);
        cmp_transfer("t5 restart", 0, 0, 1'b1, 1);

        // Test 6: start held high for 400 cycles.
        fill(8'h80);
        mode = 1'b0;
        @(negedge clk);
        start = 1'b1;
        capture(NT, NT, -1, -1, -1, 1'b0);
        chk("t6 done pulse count", count_done(0, 0, NT - 1), 2);
        chk("t6 first done", first_done(0, 0, NT - 1), 176);
        chk("t6 second done", first_done(0, 177, NT - 1), 353);
        chk("t6 idle sen between transfers", int'({tr_sen[0][176], tr_sen[0][177]}), 3);
        cmp_transfer("t6 second transfer", 0, 177, 1'b0, 1);
        do_reset();

        // Randomized banks and modes; mode toggles freely while busy.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < D; i++) bank[i] = 8'($urandom);
            rm = 1'($urandom);
            mode = rm;
            @(negedge clk);
            start = 1'b1;
            capture(180, 1, -1, -1, -1, 1'b1);
            cmp_transfer($sformatf("rand%0d gap1", r), 0, 0, rm, 1);
            cmp_transfer($sformatf("rand%0d gap0", r), 1, 0, rm, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
